// File: rtl/mips_pkg.sv
// Shared MIPS core types: data/register widths and the memory-stage control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  // Control bits that travel with an instruction from E into M.
  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
  } mem_ctrl_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory, synchronous write, asynchronous read.
// Latency: write commits at the rising edge; read is combinational (old word during a same-cycle write).
// Backpressure: none; accepts one access every cycle.
//
// Ports:
//   CLK  write clock (rising edge)
//   WE   write enable
//   A    word address
//   WD   write data
//   RD   read data, combinational from A
// Contents are deliberately not reset.
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge CLK) begin
    if (WE) begin
      r_mem[A] <= WD;
    end
  end

  assign RD = r_mem[A];

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: EX/MEM register, data memory, MEM/WB register and write-back result mux.
// Latency: E inputs appear on M outputs after one edge; ResultW is valid after the second edge.
// Backpressure: none; no stall or flush, bubbles arrive as all-zero control bits.
//
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   RegWriteE/MemtoRegE/MemWriteE  E-stage control bits
//   ALUOUTE, WriteDataE, WriteRegE E-stage byte address / ALU result, store data, destination
//   ALUOutM, WriteRegM, RegWriteM, MemtoRegM   EX/MEM outputs to forwarding and hazard logic
//   ResultW, WriteRegW, RegWriteW  write-back value, destination, enable
//   MisalignErr                    sticky misaligned-access flag
//
// Build option: define MEM_ALIGN_CHECK_EN to flag misaligned M-stage accesses and
// suppress misaligned stores. Without it MisalignErr is tied low and address bits [1:0]
// are ignored.
module memory_stage
  import mips_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RegWriteE,
  input  logic                  MemtoRegE,
  input  logic                  MemWriteE,
  input  logic [DATA_W-1:0]     ALUOUTE,
  input  logic [DATA_W-1:0]     WriteDataE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  output logic [DATA_W-1:0]     ALUOutM,
  output logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteM,
  output logic                  MemtoRegM,
  output logic [DATA_W-1:0]     ResultW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic                  RegWriteW,
  output logic                  MisalignErr
);

  // EX/MEM register
  mem_ctrl_t             r_ctrl_m;
  logic [DATA_W-1:0]     r_alu_m;
  logic [DATA_W-1:0]     r_wd_m;
  logic [REG_ADDR_W-1:0] r_wreg_m;

  // MEM/WB register
  logic                  r_regwrite_w;
  logic                  r_memtoreg_w;
  logic [DATA_W-1:0]     r_rd_w;
  logic [DATA_W-1:0]     r_alu_w;
  logic [REG_ADDR_W-1:0] r_wreg_w;

  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_rd;
  logic                  w_we;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ctrl_m <= '0;
      r_alu_m  <= '0;
      r_wd_m   <= '0;
      r_wreg_m <= '0;
    end else begin
      r_ctrl_m <= '{RegWrite: RegWriteE, MemtoReg: MemtoRegE, MemWrite: MemWriteE};
      r_alu_m  <= ALUOUTE;
      r_wd_m   <= WriteDataE;
      r_wreg_m <= WriteRegE;
    end
  end

  // Upper address bits are dropped, so byte addresses wrap modulo DEPTH*4.
  assign w_addr = r_alu_m[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign_err;

  assign w_misalign = (r_ctrl_m.MemWrite | r_ctrl_m.MemtoReg) & (r_alu_m[1:0] != 2'b00);
  // Misaligned stores are dropped; misaligned loads still read the truncated word.
  assign w_we       = r_ctrl_m.MemWrite & ~w_misalign & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_misalign_err <= 1'b0;
    end else if (w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign MisalignErr = r_misalign_err;
`else
  // RST gating keeps a store from committing on an edge where reset is held.
  assign w_we        = r_ctrl_m.MemWrite & ~RST;
  assign MisalignErr = 1'b0;
`endif

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .CLK (CLK),
    .WE  (w_we),
    .A   (w_addr),
    .WD  (r_wd_m),
    .RD  (w_rd)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_rd_w       <= '0;
      r_alu_w      <= '0;
      r_wreg_w     <= '0;
    end else begin
      r_regwrite_w <= r_ctrl_m.RegWrite;
      r_memtoreg_w <= r_ctrl_m.MemtoReg;
      r_rd_w       <= w_rd;
      r_alu_w      <= r_alu_m;
      r_wreg_w     <= r_wreg_m;
    end
  end

  assign ALUOutM   = r_alu_m;
  assign WriteRegM = r_wreg_m;
  assign RegWriteM = r_ctrl_m.RegWrite;
  assign MemtoRegM = r_ctrl_m.MemtoReg;

  assign ResultW   = r_memtoreg_w ? r_rd_w : r_alu_w;
  assign WriteRegW = r_wreg_w;
  // Register 0 writes pass through; the register file discards them.
  assign RegWriteW = r_regwrite_w;

endmodule
